// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings, opcode slice and state type for the fetch stage
package fetch_pkg;

  localparam logic [15:0] NOP_ENC  = 16'h0800;
  localparam logic [15:0] HALT_ENC = 16'h0000;
  localparam int          OPC_MSB  = 15;
  localparam int          OPC_LSB  = 11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory port between fetch and imem
interface fetch_if;

  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        imem_err;

  modport master (output imem_addr, output imem_en, input imem_rdata, input imem_err);
  modport slave  (input imem_addr, input imem_en, output imem_rdata, output imem_err);

endinterface

// File: rtl/cla_16b.sv
// rtl/cla_16b.sv - 16-bit carry-lookahead adder built from 4-bit lookahead groups
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // group carries first (ripple across groups), then carries inside each group
  always_comb begin
    w_c    = '0;
    w_c[0] = c_in;
    for (int k = 0; k < 3; k++) begin
      w_c[4*k+4] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
    for (int k = 0; k < 4; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
  end

  assign sum = w_p ^ w_c;

endmodule

// File: rtl/fetch_if_id_reg.sv
// rtl/fetch_if_id_reg.sv - IF/ID pipeline register with load, flush and bubble on reset
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instr,
  input  logic [15:0] pc2,
  output logic [15:0] instruction_ID,
  output logic [15:0] PC_2_ID,
  output logic        valid_ID
);

  logic [15:0] r_instr;
  logic [15:0] r_pc2;
  logic        r_valid;

  // flush wins over load so a wrong-path word never reaches decode
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_instr <= NOP_INSTR;
      r_pc2   <= 16'h0000;
      r_valid <= 1'b0;
    end else if (load) begin
      r_instr <= instr;
      r_pc2   <= pc2;
      r_valid <= 1'b1;
    end
  end

  assign instruction_ID = r_instr;
  assign PC_2_ID        = r_pc2;
  assign valid_ID       = r_valid;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage owning the PC and feeding IF/ID
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] instruction_ID,
  output logic [15:0] PC_2_ID,
  output logic        valid_ID,
  output logic        halted,
  output logic        err
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [15:0]  r_pc;
  logic         r_err;
  logic [15:0]  w_pc_plus2;
  logic         w_take_redirect;
  logic         w_take_normal;
  logic         w_imem_en;
  logic         w_halted;

  cla_16b u_pc_add (
    .a    (r_pc),
    .b    (16'h0002),
    .c_in (1'b0),
    .sum  (w_pc_plus2)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next_state;
  end

  // next state: a redirect means the halt came from the wrong path
  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_RUN && halt && !redirect) w_next_state = ST_HALTED;
  end

  // outputs and per-edge action decode (redirect > halt > stall > normal)
  always_comb begin
    w_take_redirect = 1'b0;
    w_take_normal   = 1'b0;
    w_imem_en       = 1'b0;
    w_halted        = 1'b0;
    if (r_state == ST_RUN) begin
      w_take_redirect = redirect;
      w_take_normal   = !redirect && !halt && !stall;
      w_imem_en       = !rst;
    end else begin
      w_halted        = 1'b1;
    end
  end

  // PC: redirect target is forced to a halfword boundary
  always_ff @(posedge clk) begin
    if (rst)                  r_pc <= RESET_PC;
    else if (w_take_redirect) r_pc <= {redirect_pc[15:1], 1'b0};
    else if (w_take_normal)   r_pc <= w_pc_plus2;
  end

  // sticky error: misaligned redirect target or imem fault on a consumed fetch
  always_ff @(posedge clk) begin
    if (rst)                                   r_err <= 1'b0;
    else if (w_take_redirect && redirect_pc[0]) r_err <= 1'b1;
    else if (w_take_normal && imem.imem_err)    r_err <= 1'b1;
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk            (clk),
    .rst            (rst),
    .load           (w_take_normal),
    .flush          (w_take_redirect),
    .instr          (imem.imem_rdata),
    .pc2            (w_pc_plus2),
    .instruction_ID (instruction_ID),
    .PC_2_ID        (PC_2_ID),
    .valid_ID       (valid_ID)
  );

  assign imem.imem_addr = r_pc;
  assign imem.imem_en   = w_imem_en;
  assign halted         = w_halted;
  assign err            = r_err;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch against a behavioural stage model
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        tb_imem_err;
  logic [15:0] instruction_ID;
  logic [15:0] PC_2_ID;
  logic        valid_ID;
  logic        halted;
  logic        err;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pc2;
  logic        m_valid;
  logic        m_halted;
  logic        m_err;

  fetch_if imem ();

  assign imem.imem_rdata = mem[imem.imem_addr];
  assign imem.imem_err   = tb_imem_err;

  fetch #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instruction_ID (instruction_ID),
    .PC_2_ID        (PC_2_ID),
    .valid_ID       (valid_ID),
    .halted         (halted),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // what one rising edge does to the stage, from the current inputs
  task automatic model_step();
    if (rst) begin
      m_pc = 16'h0000; m_instr = 16'h0800; m_pc2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
    end else if (!m_halted) begin
      if (redirect) begin
        m_pc = redirect_pc & 16'hFFFE;
        m_instr = 16'h0800; m_pc2 = 16'h0000; m_valid = 1'b0;
        if (redirect_pc[0]) m_err = 1'b1;
      end else if (halt) begin
        m_halted = 1'b1;
      end else if (!stall) begin
        m_instr = mem[m_pc];
        m_pc    = m_pc + 16'd2;
        m_pc2   = m_pc;
        m_valid = 1'b1;
        if (tb_imem_err) m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, imem.imem_addr, m_pc);
    chk({tag, ".imem_en"}, {15'd0, imem.imem_en}, {15'd0, !m_halted && !rst});
    chk({tag, ".instruction_ID"}, instruction_ID, m_instr);
    chk({tag, ".PC_2_ID"}, PC_2_ID, m_pc2);
    chk({tag, ".valid_ID"}, {15'd0, valid_ID}, {15'd0, m_valid});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halted});
    chk({tag, ".err"}, {15'd0, err}, {15'd0, m_err});
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                        input logic h, input logic e);
    rst = r; stall = s; redirect = rd; redirect_pc = rp; halt = h; tb_imem_err = e;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[16'h0000] = 16'hA123;
    mem[16'h0002] = 16'hB456;
    mem[16'h0100] = 16'h0000;
    m_pc = 16'h0000; m_instr = 16'h0800; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;

    set_in(1, 0, 0, 16'h0000, 0, 0);
    cycle("reset");
    chk("reset.pc_literal", imem.imem_addr, 16'h0000);
    chk("reset.instr_literal", instruction_ID, 16'h0800);

    set_in(0, 0, 0, 16'h0000, 0, 0);
    cycle("run1");
    chk("run1.instr_literal", instruction_ID, 16'hA123);
    chk("run1.pc2_literal", PC_2_ID, 16'h0002);
    cycle("run2");
    chk("run2.instr_literal", instruction_ID, 16'hB456);
    chk("run2.addr_literal", imem.imem_addr, 16'h0004);

    stall = 1'b1;
    cycle("stall1");
    cycle("stall2");
    chk("stall2.addr_literal", imem.imem_addr, 16'h0004);
    stall = 1'b0;
    cycle("resume");
    chk("resume.pc2_literal", PC_2_ID, 16'h0006);

    set_in(0, 1, 1, 16'h0040, 1, 0);
    cycle("redir_all");
    chk("redir_all.addr_literal", imem.imem_addr, 16'h0040);
    set_in(0, 0, 0, 16'h0000, 0, 0);
    cycle("after_redir");
    chk("after_redir.pc2_literal", PC_2_ID, 16'h0042);
    set_in(0, 0, 1, 16'h0041, 0, 0);
    cycle("redir_odd");
    chk("redir_odd.addr_literal", imem.imem_addr, 16'h0040);
    set_in(0, 0, 0, 16'h0000, 0, 0);
    cycle("after_odd");

    set_in(1, 0, 0, 16'h0000, 0, 0);
    cycle("reset2");
    set_in(0, 0, 1, 16'h0100, 0, 0);
    cycle("to_halt_instr");
    set_in(0, 0, 0, 16'h0000, 0, 0);
    cycle("fetch_halt_instr");
    halt = 1'b1;
    cycle("halt");
    chk("halt.halted_literal", {15'd0, halted}, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      cycle("halt_frozen");
    end
    chk("halt_frozen.instr_literal", instruction_ID, 16'h0000);
    set_in(1, 1, 1, 16'h1234, 1, 0);
    cycle("halt_reset");
    chk("halt_reset.halted_literal", {15'd0, halted}, 16'h0000);

    set_in(0, 0, 1, 16'hFFFE, 0, 0);
    cycle("to_wrap");
    set_in(0, 0, 0, 16'h0000, 0, 0);
    cycle("wrap");
    chk("wrap.addr_literal", imem.imem_addr, 16'h0000);
    chk("wrap.valid_literal", {15'd0, valid_ID}, 16'h0001);

    tb_imem_err = 1'b1;
    cycle("ierr");
    tb_imem_err = 1'b0;
    cycle("ierr_sticky1");
    cycle("ierr_sticky2");
    chk("ierr_sticky.err_literal", {15'd0, err}, 16'h0001);
    rst = 1'b1;
    cycle("ierr_reset");
    set_in(0, 1, 0, 16'h0000, 0, 1);
    cycle("ierr_stall");
    chk("ierr_stall.err_literal", {15'd0, err}, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 7) == 0, 16'($urandom),
             $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
